// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for the systolic MAC array edge: lane i lags by i steps and is
// padded with +0; each step is one complete stMAC/done handshake with the driven MACs.
module systolic_skew_feeder #(
  parameter  int LANES = 3,
  parameter  int DEPTH = 3,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SW    = $clog2(DEPTH + LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [LW-1:0]      wr_lane,
  input  logic [IW-1:0]      wr_idx,
  input  logic [7:0]         wr_data,
  input  logic               start,
  input  logic               mac_done,
  output logic [8*LANES-1:0] lane_data,
  output logic               mac_start,
  output logic [SW-1:0]      step,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  localparam int NSTEP = DEPTH + LANES - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RELEASE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t             r_state;
  logic [7:0]         r_mem [LANES][DEPTH];
  logic [8*LANES-1:0] r_lane_data;
  logic               r_mac_start;
  logic [SW-1:0]      r_step;
  logic               r_busy;
  logic               r_done;

  logic [SW-1:0]      w_load_step;
  logic [8*LANES-1:0] w_lane_next;
  logic               w_wr_ok;

  assign w_wr_ok     = (int'(wr_lane) < LANES) && (int'(wr_idx) < DEPTH);
  assign w_load_step = (r_state == S_IDLE) ? '0 : r_step + SW'(1);

  // Lane i shows element (step - i); any lane outside its window shows +0.
  always_comb begin
    w_lane_next = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (int'(w_load_step) == i + k) w_lane_next[8*i +: 8] = r_mem[i][k];
      end
    end
  end

  // Handshake: mac_start is held high until the MACs first drop done (start seen) and
  // then raise it (result ready); a done that is already high on entry is never trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lane_data <= '0;
      r_mac_start <= 1'b0;
      r_step      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        for (int k = 0; k < DEPTH; k++) r_mem[i][k] <= 8'h00;
      end
    end else begin
      if (r_state == S_IDLE && wr_en && w_wr_ok) r_mem[wr_lane][wr_idx] <= wr_data;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lane_data <= w_lane_next;
            r_step      <= '0;
            r_mac_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!mac_done) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mac_done) begin
            r_mac_start <= 1'b0;
            r_state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (r_step == SW'(NSTEP - 1)) begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_step      <= w_load_step;
            r_lane_data <= w_lane_next;
            r_mac_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lane_data = r_lane_data;
  assign mac_start = r_mac_start;
  assign step      = r_step;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: MAC handshake model, reference skew model feeding an
// expected queue, and a negedge monitor that checks every presented step.
module tb_systolic_skew_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_lane;
  logic [1:0]  wr_idx;
  logic [7:0]  wr_data;
  logic        start;
  logic        mac_done;
  logic [23:0] lane_data;
  logic        mac_start;
  logic [2:0]  step;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  systolic_skew_feeder #(.LANES(3), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lane(wr_lane), .wr_idx(wr_idx),
    .wr_data(wr_data), .start(start), .mac_done(mac_done), .lane_data(lane_data),
    .mac_start(mac_start), .step(step), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0]  ref_mem [3][3];
  logic [26:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  // Reference: at step s lane i carries element s-i when that index exists, else zero.
  task automatic push_stream();
    for (int s = 0; s < 5; s++) begin
      logic [23:0] d;
      d = '0;
      for (int i = 0; i < 3; i++) begin
        int k;
        k = s - i;
        if (k >= 0 && k < 3) d[8*i +: 8] = ref_mem[i][k];
      end
      exp_q.push_back({3'(s), d});
    end
  endtask

  // MAC model: drops done the cycle after seeing stMAC, raises it after lat cycles
  // (plus a stall on a chosen step), then waits for stMAC to fall.
  int   lat = 6;
  int   stall_step = -1;
  int   stall_len = 0;
  bit   hold_stale = 1'b0;
  int   m_state = 0;
  int   m_cnt = 0;
  logic m_done = 1'b0;

  assign mac_done = hold_stale ? 1'b1 : m_done;

  always @(negedge clk) begin
    if (rst) begin
      m_state = 0;
      m_done  = 1'b0;
    end else if (!hold_stale) begin
      case (m_state)
        0: if (mac_start) begin
             m_done  = 1'b0;
             m_cnt   = lat + ((int'(step) == stall_step) ? stall_len : 0);
             m_state = 1;
           end
        1: if (m_cnt <= 1) begin
             m_done  = 1'b1;
             m_state = 2;
           end else m_cnt--;
        default: if (!mac_start) m_state = 0;
      endcase
    end
  end

  // Monitor: a rising mac_start presents a new step; data and step must hold while high.
  logic [26:0] cur;
  bit          have_cur = 1'b0;
  bit          prev_start = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      have_cur   = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (mac_start && !prev_start) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", {29'd0, step}, 32'hFFFF_FFFF);
          have_cur = 1'b0;
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (mac_start && have_cur) check("step_data", {5'd0, step, lane_data}, {5'd0, cur});
      if (done) begin
        done_cnt++;
        check("start_low_at_done", {31'd0, mac_start}, 32'd0);
      end
      prev_start = mac_start;
    end
  end

  task automatic write_elem(input logic [1:0] l, input logic [1:0] k, input logic [7:0] d);
    wr_en = 1'b1; wr_lane = l; wr_idx = k; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (l < 2'd3 && k < 2'd3) ref_mem[l][k] = d;
  endtask

  // Called at a negedge with the DUT idle; returns one negedge after done.
  task automatic run_stream(input int stale_cyc, input bit poke, input bit wr_with_start);
    int  d0;
    bit  seen;
    bit  poked;
    d0    = done_cnt;
    poked = 1'b0;
    push_stream();
    start = 1'b1;
    if (wr_with_start) begin
      wr_en = 1'b1; wr_lane = 2'd0; wr_idx = 2'd0; wr_data = 8'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    // Element [0][0] is only read at step 0, which uses the pre-write contents.
    if (wr_with_start) ref_mem[0][0] = wr_data;
    check("start_latency", {29'd0, busy, mac_start, (step == 3'd0)}, 32'd7);
    if (stale_cyc > 0) begin
      repeat (stale_cyc) begin
        @(negedge clk);
        check("stale_hold", {28'd0, busy, mac_start, step[1:0]}, {28'd0, 4'b1100});
        check("stale_step", {29'd0, step}, 32'd0);
      end
      hold_stale = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (poke) begin
        if (step == 3'd2 && !poked) begin
          wr_en = 1'b1; wr_lane = 2'($urandom_range(0, 2)); wr_idx = 2'($urandom_range(0, 2));
          wr_data = 8'hFF;
          poked = 1'b1;
        end else wr_en = 1'b0;
        start = ($urandom_range(0, 3) == 0);
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    if (!seen) exp_q.delete();
    @(negedge clk);
    check("idle_after_done", {29'd0, busy, done, mac_start}, 32'd0);
    check("done_pulses", done_cnt - d0, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; wr_en = 1'b0; wr_lane = '0; wr_idx = '0; wr_data = '0; start = 1'b0;
    for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) ref_mem[i][k] = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("rst_lane_data", {8'd0, lane_data}, 32'd0);
    check("rst_mac_start", {31'd0, mac_start}, 32'd0);
    check("rst_step", {29'd0, step}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Skew scenario
    write_elem(0, 0, 8'h38); write_elem(0, 1, 8'h40); write_elem(0, 2, 8'h44);
    write_elem(1, 0, 8'h3C); write_elem(1, 1, 8'h42); write_elem(1, 2, 8'h46);
    write_elem(2, 0, 8'h30); write_elem(2, 1, 8'h34); write_elem(2, 2, 8'h48);
    lat = 6;
    run_stream(0, 1'b0, 1'b0);

    // Stale done held high when start arrives
    hold_stale = 1'b1;
    run_stream(8, 1'b0, 1'b0);

    // Long stall at step 1
    stall_step = 1; stall_len = 50;
    run_stream(0, 1'b0, 1'b0);
    stall_step = -1; stall_len = 0;

    // Writes and start pulses while busy, then an immediate back-to-back repeat
    run_stream(0, 1'b1, 1'b0);
    run_stream(0, 1'b0, 1'b0);

    // Random contents, out-of-range writes, random MAC latency
    for (int n = 0; n < 6; n++) begin
      int nw;
      nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++)
        write_elem(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom));
      lat = $urandom_range(1, 7);
      run_stream(0, 1'b0, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT at step 2, then read storage back as zeros
    lat = 6;
    push_stream();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (step == 3'd2 && mac_start && !mac_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_step2_wait", {31'd0, seen}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_lane_data", {8'd0, lane_data}, 32'd0);
    check("midrst_start_busy", {29'd0, mac_start, busy, done}, 32'd0);
    check("midrst_step", {29'd0, step}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) ref_mem[i][k] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_stream(0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
